// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 peripheral.
// Byte width, FSM state encoding and the idle fill byte.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam logic [SPI_BYTE_W-1:0] DEFAULT_TX_BYTE = 8'hFF;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_periph_state_t;

endpackage

// File: rtl/spi_sync.sv
// N-stage single-bit synchronizer with a programmable reset value.
// Used to bring the SPI pins into the clk domain.
module spi_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  // Shift the pin value through N flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= {N{RST_VAL}};
    else        ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral: oversampled pins, MSB-first 8-bit bytes,
// one-entry TX holding register, multi-byte frames under one CS.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0] DEFAULT_TX  = DEFAULT_TX_BYTE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SPI_SCLK,
  input  logic                  SPI_CS,
  input  logic                  SPI_MOSI,
  output logic                  SPI_MISO,
  output logic                  miso_oe,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_abort,
  output logic                  busy
);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d;
  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;
  logic load;

  spi_periph_state_t state;

  logic [SPI_BYTE_W-1:0] hold_data;
  logic                  hold_full;
  logic [SPI_BYTE_W-1:0] next_byte;
  logic [SPI_BYTE_W-1:0] tx_sr;
  logic [2:0]            tx_bit;
  logic [SPI_BYTE_W-2:0] rx_sr;
  logic [2:0]            rx_cnt;

  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d(SPI_SCLK), .q(sclk_s)
  );

  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .d(SPI_CS), .q(cs_s)
  );

  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .d(SPI_MOSI), .q(mosi_s)
  );

  // Delay synchronized SCLK/CS by one cycle for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;

  assign tx_ready  = ~hold_full;
  assign next_byte = hold_full ? hold_data : DEFAULT_TX;

  // A CS event always pre-empts an SCLK event in the same cycle
  assign load = (state == IDLE) ? cs_fall
              : (!cs_rise && sclk_fall && tx_bit == 3'd0);

  // One-entry TX holding register; a load empties it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (load && hold_full) begin
      hold_full <= 1'b0;
    end else if (tx_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
    end
  end

  // Frame FSM with rx/tx shifters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      SPI_MISO    <= 1'b0;
      miso_oe     <= 1'b0;
      busy        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
      tx_sr       <= '0;
      tx_bit      <= 3'd7;
      rx_sr       <= '0;
      rx_cnt      <= 3'd0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state       <= ACTIVE;
            busy        <= 1'b1;
            miso_oe     <= 1'b1;
            tx_sr       <= next_byte;
            SPI_MISO    <= next_byte[7];
            tx_underrun <= ~hold_full;
            tx_bit      <= 3'd7;
            rx_cnt      <= 3'd0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state       <= IDLE;
            busy        <= 1'b0;
            miso_oe     <= 1'b0;
            SPI_MISO    <= 1'b0;
            frame_abort <= (rx_cnt != 3'd0);
            rx_cnt      <= 3'd0;
          end else begin
            if (sclk_rise) begin
              rx_sr <= {rx_sr[SPI_BYTE_W-3:0], mosi_s};
              if (rx_cnt == 3'd7) begin
                rx_data  <= {rx_sr, mosi_s};
                rx_valid <= 1'b1;
                rx_cnt   <= 3'd0;
              end else begin
                rx_cnt <= rx_cnt + 3'd1;
              end
            end
            if (sclk_fall) begin
              if (tx_bit == 3'd0) begin
                tx_sr       <= next_byte;
                SPI_MISO    <= next_byte[7];
                tx_underrun <= ~hold_full;
                tx_bit      <= 3'd7;
              end else begin
                tx_bit   <= tx_bit - 3'd1;
                SPI_MISO <= tx_sr[tx_bit-3'd1];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
